// File: rtl/spi_aes_pkg.sv
// Shared definitions for the SPI front end of the AES core: header codes,
// payload lengths and the receive state encoding.
package spi_aes_pkg;

    // Key-size header carried in the first two bits of a frame
    localparam logic [1:0] KEY128   = 2'b00;
    localparam logic [1:0] KEY192   = 2'b01;
    localparam logic [1:0] KEY256   = 2'b10;
    localparam logic [1:0] HDR_RSVD = 2'b11;

    // Payload lengths in bits and the width of the bit counter that holds them
    localparam int LEN128 = 128;
    localparam int LEN192 = 192;
    localparam int LEN256 = 256;
    localparam int CNT_W  = 9;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_DRAIN   = 2'd3
    } state_t;

    // Payload length selected by a (non-reserved) header
    function automatic logic [CNT_W-1:0] hdr_to_len(input logic [1:0] h);
        case (h)
            KEY192:  return CNT_W'(LEN192);
            KEY256:  return CNT_W'(LEN256);
            default: return CNT_W'(LEN128);
        endcase
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-flop synchronizer for an asynchronous SPI pin plus rise/fall
// detection on the synchronized level. The chain resets low so that a
// chip select already held low when reset is released never looks like
// a fresh falling edge.
module spi_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] pipe;
    logic                   lvl_d;
    logic                   lvl;

    assign lvl = pipe[SYNC_STAGES-1];

    // Synchronizer chain plus one extra flop of history for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe  <= '0;
            lvl_d <= 1'b0;
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                pipe[i] <= pipe[i-1];
            end
            lvl_d <= lvl;
        end
    end

    assign rise = lvl & ~lvl_d;
    assign fall = ~lvl & lvl_d;

endmodule

// File: rtl/spi_sub_frame_rx.sv
// SPI mode-0 subordinate receiver for the AES core. Accepts one frame per
// chip-select assertion (2-bit key-size header then 128/192/256 payload bits,
// MSB first), presents the payload left-aligned with a one-clock strobe, and
// shifts a 128-bit response word out on sdo during the payload phase.
module spi_sub_frame_rx
    import spi_aes_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_W      = 256,
    parameter int RESP_W      = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs_n,
    input  logic              sclk,
    input  logic              sdi,
    output logic              sdo,
    input  logic [RESP_W-1:0] tx_data,
    output logic [DATA_W-1:0] rx_data,
    output logic [1:0]        rx_len,
    output logic              rx_valid,
    output logic              rx_abort,
    output logic              rx_err,
    output logic              busy
);

    localparam int TXC_W = $clog2(RESP_W + 1);

    // Synchronized pin events
    logic sclk_rise, sclk_fall;
    logic cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] sdi_pipe;
    logic sdi_s;

    // Frame state
    state_t            state;
    logic [RESP_W-1:0] tx_buf;
    logic [TXC_W-1:0]  tx_cnt;
    logic [CNT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [CNT_W-1:0]  target;
    logic [DATA_W-2:0] shift_reg;
    logic [DATA_W-1:0] shift_nxt;
    logic [DATA_W-1:0] aligned;
    logic [1:0]        hdr;
    logic [1:0]        hdr_nxt;
    logic              hdr_cnt;

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (sclk),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (cs_n),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    // sdi only needs the level; same depth as sclk so data lines up with the edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sdi_pipe <= '0;
        end else begin
            sdi_pipe[0] <= sdi;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sdi_pipe[i] <= sdi_pipe[i-1];
            end
        end
    end

    assign sdi_s = sdi_pipe[SYNC_STAGES-1];

    // Next-value helpers for the header and payload shift paths
    always_comb begin
        hdr_nxt   = {hdr[0], sdi_s};
        cnt_nxt   = bit_cnt + CNT_W'(1);
        shift_nxt = {shift_reg, sdi_s};
        // Left-align: a short payload sits in the top bits, zeros below
        aligned   = shift_nxt << (DATA_W - int'(target));
    end

    // Frame state machine with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            tx_buf    <= '0;
            tx_cnt    <= '0;
            bit_cnt   <= '0;
            target    <= '0;
            shift_reg <= '0;
            hdr       <= '0;
            hdr_cnt   <= 1'b0;
            sdo       <= 1'b0;
            rx_data   <= '0;
            rx_len    <= '0;
            rx_valid  <= 1'b0;
            rx_abort  <= 1'b0;
            rx_err    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_abort <= 1'b0;
            rx_err   <= 1'b0;

            case (state)
                ST_IDLE: begin
                    sdo <= 1'b0;
                    if (cs_fall) begin
                        tx_buf    <= tx_data;
                        tx_cnt    <= '0;
                        bit_cnt   <= '0;
                        shift_reg <= '0;
                        hdr       <= '0;
                        hdr_cnt   <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ST_HDR;
                    end
                end

                ST_HDR: begin
                    sdo <= 1'b0;
                    // A chip-select release wins over a coincident header bit
                    if (cs_rise) begin
                        rx_abort <= 1'b1;
                        busy     <= 1'b0;
                        state    <= ST_IDLE;
                    end else if (sclk_rise) begin
                        hdr     <= hdr_nxt;
                        hdr_cnt <= 1'b1;
                        if (hdr_cnt) begin
                            if (hdr_nxt == HDR_RSVD) begin
                                rx_err <= 1'b1;
                                state  <= ST_DRAIN;
                            end else begin
                                target <= hdr_to_len(hdr_nxt);
                                state  <= ST_PAYLOAD;
                            end
                        end
                    end
                end

                ST_PAYLOAD: begin
                    if (sclk_rise) begin
                        shift_reg <= shift_nxt[DATA_W-2:0];
                        bit_cnt   <= cnt_nxt;
                        if (cnt_nxt == target) begin
                            // Final bit completes the frame even if cs_n rose with it
                            rx_data  <= aligned;
                            rx_len   <= hdr;
                            rx_valid <= 1'b1;
                            sdo      <= 1'b0;
                            if (cs_rise) begin
                                busy  <= 1'b0;
                                state <= ST_IDLE;
                            end else begin
                                state <= ST_DRAIN;
                            end
                        end else if (cs_rise) begin
                            rx_abort <= 1'b1;
                            busy     <= 1'b0;
                            state    <= ST_IDLE;
                        end
                    end else if (cs_rise) begin
                        rx_abort <= 1'b1;
                        busy     <= 1'b0;
                        state    <= ST_IDLE;
                    end else if (sclk_fall) begin
                        // Response goes out MSB first, then the line idles low
                        if (tx_cnt < TXC_W'(RESP_W)) begin
                            sdo    <= tx_buf[RESP_W-1];
                            tx_buf <= {tx_buf[RESP_W-2:0], 1'b0};
                            tx_cnt <= tx_cnt + TXC_W'(1);
                        end else begin
                            sdo <= 1'b0;
                        end
                    end
                end

                ST_DRAIN: begin
                    sdo <= 1'b0;
                    if (cs_rise) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    sdo   <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_sub_frame_rx.sv
// Directed bench for spi_sub_frame_rx: a table of whole frames driven from a
// mode-0 main model, plus hand sequences for reset behaviour.
module tb_spi_sub_frame_rx;

    localparam int DATA_W = 256;
    localparam int RESP_W = 128;
    localparam int HALF   = 4;   // clk cycles per sclk half period

    localparam logic [255:0] P256 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] P128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] P192 =
        {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] NP256 = ~P256;
    localparam logic [255:0] N192  = {NP256[255:64], 64'h0};

    localparam logic [127:0] TX_R = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] TX_A = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] TX_B = 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f;
    localparam logic [127:0] TX_C = 128'h0123456789abcdeffedcba9876543210;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cs_n = 1'b1;
    logic              sclk = 1'b0;
    logic              sdi = 1'b0;
    logic              sdo;
    logic [RESP_W-1:0] tx_data = '0;
    logic [DATA_W-1:0] rx_data;
    logic [1:0]        rx_len;
    logic              rx_valid, rx_abort, rx_err, busy;

    int total = 0;
    int bad   = 0;
    int n_valid = 0, n_abort = 0, n_err = 0, n_sdo_hdr = 0, n_sdo_frame = 0;
    bit in_hdr = 1'b0, in_frame = 1'b0;

    always #5 clk = ~clk;

    spi_sub_frame_rx #(.SYNC_STAGES(2), .DATA_W(DATA_W), .RESP_W(RESP_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cs_n     (cs_n),
        .sclk     (sclk),
        .sdi      (sdi),
        .sdo      (sdo),
        .tx_data  (tx_data),
        .rx_data  (rx_data),
        .rx_len   (rx_len),
        .rx_valid (rx_valid),
        .rx_abort (rx_abort),
        .rx_err   (rx_err),
        .busy     (busy)
    );

    // Count strobe cycles and any sdo activity where it must stay low
    always @(negedge clk) begin
        if (rx_valid) n_valid++;
        if (rx_abort) n_abort++;
        if (rx_err)   n_err++;
        if (in_hdr && sdo)   n_sdo_hdr++;
        if (in_frame && sdo) n_sdo_frame++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [1:0]   hdr;
        int           nbits;
        int           abort_after;
        bit           cs_last;
        logic [255:0] pl;
        logic [127:0] tx;
        int           e_valid;
        int           e_abort;
        int           e_err;
        logic [1:0]   e_len;
        logic [255:0] e_data;
    } vec_t;

    vec_t vecs[9];

    function automatic vec_t mk(input logic [1:0] h, input int nb, input int ab, input bit csl,
                                input logic [255:0] pl, input logic [127:0] tx,
                                input int ev, input int ea, input int ee,
                                input logic [1:0] el, input logic [255:0] ed);
        vec_t v;
        v.hdr = h; v.nbits = nb; v.abort_after = ab; v.cs_last = csl;
        v.pl = pl; v.tx = tx; v.e_valid = ev; v.e_abort = ea; v.e_err = ee;
        v.e_len = el; v.e_data = ed;
        return v;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_half();
        repeat (HALF) @(negedge clk);
    endtask

    // One plain sclk cycle with sdi held at b
    task automatic clk_bit(input logic b);
        sdi = b;
        wait_half();
        sclk = 1'b1;
        wait_half();
        sclk = 1'b0;
    endtask

    // Mode-0 main: header, payload (possibly cut short), capture of sdo on rises
    task automatic run_frame(input logic [1:0] h, input logic [255:0] pl, input int nbits,
                             input int abort_after, input bit cs_last,
                             output logic [127:0] resp);
        int lim;
        resp = '0;
        lim  = (abort_after >= 0) ? abort_after : nbits;
        in_frame = 1'b1;
        in_hdr   = 1'b1;
        cs_n     = 1'b0;
        for (int b = 1; b >= 0; b--) clk_bit(h[b]);
        in_hdr = 1'b0;
        for (int i = 0; i < lim; i++) begin
            sdi = pl[255-i];
            wait_half();
            sclk = 1'b1;
            if (i < 128) resp = {resp[126:0], sdo};
            if (i == 2) tx_data = ~tx_data;   // must not disturb this frame
            if (cs_last && i == lim - 1) cs_n = 1'b1;
            wait_half();
            sclk = 1'b0;
        end
        wait_half();
        cs_n     = 1'b1;
        in_frame = 1'b0;
        sdi      = 1'b0;
        repeat (4 * HALF) @(negedge clk);
    endtask

    initial begin
        logic [127:0] resp;
        int v0, a0, e0, sh0, sf0;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        check("reset sdo",      256'(sdo),      256'h0);
        check("reset rx_data",  rx_data,        256'h0);
        check("reset rx_len",   256'(rx_len),   256'h0);
        check("reset rx_valid", 256'(rx_valid), 256'h0);
        check("reset rx_abort", 256'(rx_abort), 256'h0);
        check("reset rx_err",   256'(rx_err),   256'h0);
        check("reset busy",     256'(busy),     256'h0);

        vecs[0] = mk(2'b00, 128, -1, 0, P128,  TX_A, 1, 0, 0, 2'b00, P128);
        vecs[1] = mk(2'b01, 192, -1, 0, P192,  TX_B, 1, 0, 0, 2'b01, P192);
        vecs[2] = mk(2'b10, 256, -1, 0, P256,  TX_C, 1, 0, 0, 2'b10, P256);
        vecs[3] = mk(2'b00, 128, 50, 0, P128,  TX_A, 0, 1, 0, 2'b10, P256);
        vecs[4] = mk(2'b00, 128, -1, 0, P128,  TX_B, 1, 0, 0, 2'b00, P128);
        vecs[5] = mk(2'b00, 128, -1, 0, '0,    TX_R, 1, 0, 0, 2'b00, '0);
        vecs[6] = mk(2'b01, 192, -1, 1, NP256, TX_C, 1, 0, 0, 2'b01, N192);
        vecs[7] = mk(2'b11, 32,  -1, 0, P256,  TX_R, 0, 0, 1, 2'b01, N192);
        vecs[8] = mk(2'b10, 256, -1, 0, NP256, TX_A, 1, 0, 0, 2'b10, NP256);

        for (int k = 0; k < 9; k++) begin
            v0 = n_valid; a0 = n_abort; e0 = n_err; sh0 = n_sdo_hdr; sf0 = n_sdo_frame;
            tx_data = vecs[k].tx;
            run_frame(vecs[k].hdr, vecs[k].pl, vecs[k].nbits, vecs[k].abort_after,
                      vecs[k].cs_last, resp);
            $display("vector %0d", k);
            check("rx_valid pulses", 256'(n_valid - v0), 256'(vecs[k].e_valid));
            check("rx_abort pulses", 256'(n_abort - a0), 256'(vecs[k].e_abort));
            check("rx_err pulses",   256'(n_err - e0),   256'(vecs[k].e_err));
            check("rx_data",         rx_data,            vecs[k].e_data);
            check("rx_len",          256'(rx_len),       256'(vecs[k].e_len));
            check("busy after",      256'(busy),         256'h0);
            check("sdo in header",   256'(n_sdo_hdr - sh0), 256'h0);
            if (vecs[k].e_valid != 0)
                check("response", 256'(resp), 256'(vecs[k].tx));
            if (vecs[k].e_err != 0)
                check("sdo on reserved", 256'(n_sdo_frame - sf0), 256'h0);
        end

        // Reset in the middle of a 256-bit frame with cs_n still low
        tx_data = TX_B;
        cs_n = 1'b0;
        clk_bit(1'b1);
        clk_bit(1'b0);
        for (int i = 0; i < 40; i++) clk_bit(P256[255-i]);
        check("busy mid-frame", 256'(busy), 256'h1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("mid reset rx_data", rx_data,      256'h0);
        check("mid reset rx_len",  256'(rx_len), 256'h0);
        check("mid reset busy",    256'(busy),   256'h0);
        check("mid reset sdo",     256'(sdo),    256'h0);
        rst_n = 1'b1;
        v0 = n_valid; a0 = n_abort; e0 = n_err;
        for (int i = 40; i < 256; i++) clk_bit(P256[255-i]);
        wait_half();
        cs_n = 1'b1;
        repeat (4 * HALF) @(negedge clk);
        check("tail after reset strobes", 256'((n_valid - v0) + (n_abort - a0) + (n_err - e0)),
              256'h0);
        check("tail after reset busy", 256'(busy), 256'h0);

        // Next frame after reset decodes normally
        v0 = n_valid;
        tx_data = TX_C;
        run_frame(2'b01, P192, 192, -1, 1'b0, resp);
        check("post reset valid",    256'(n_valid - v0), 256'h1);
        check("post reset rx_data",  rx_data,            P192);
        check("post reset rx_len",   256'(rx_len),       256'h1);
        check("post reset response", 256'(resp),         256'(TX_C));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
